riscv_muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit; the sequential companion to the single-cycle ALU.

---
 rtl/riscv_muldiv_unit_if.sv | 26 ++
 rtl/riscv_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle of the iterative RV32M/RV64M multiply/divide unit.
// The unit sits on the slave side; the EX stage drives the master side.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output flush_i, in_valid_i, op_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative radix-2 shift-add multiplier / restoring divider on operand magnitudes.
// Define RISCV_MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle combinational product.
module riscv_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = $clog2(XLEN) + 1
) (
    input logic                clk_i,
    input logic                arst_n_i,
    riscv_muldiv_unit_if.slave io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       neg;
    } ctx_t;

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t               state_q;
    ctx_t                 ctx_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [XLEN-1:0]      hi_q, lo_q, opnd_q, result_q;

    logic            a_signed, b_signed, sa, sb, is_rem, neg_acc, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    // Apply the sign rules to the magnitude product/quotient/remainder.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic neg,
                                                 input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        p = {hi, lo};
        if (neg) p = -p;
        case (op)
            3'd0:             return p[XLEN-1:0];
            3'd1, 3'd2, 3'd3: return p[2*XLEN-1:XLEN];
            3'd4, 3'd5:       return neg ? -lo : lo;
            default:          return neg ? -hi : hi;
        endcase
    endfunction

    always_comb begin
        a_signed    = io.op_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        b_signed    = io.op_i inside {3'd0, 3'd1, 3'd4, 3'd6};
        sa          = a_signed & io.a_i[XLEN-1];
        sb          = b_signed & io.b_i[XLEN-1];
        mag_a       = sa ? -io.a_i : io.a_i;
        mag_b       = sb ? -io.b_i : io.b_i;
        is_rem      = io.op_i[2] & io.op_i[1];
        // Remainder follows the dividend; product and quotient follow the sign mismatch.
        neg_acc     = is_rem ? sa : (sa ^ sb);
        special     = 1'b0;
        special_res = '0;
        if (io.op_i[2] && io.b_i == '0) begin
            special     = 1'b1;
            special_res = is_rem ? io.a_i : ALL_ONES;
        end else if (io.op_i[2] && !io.op_i[0] && io.a_i == MIN_INT && io.b_i == ALL_ONES) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : MIN_INT;
        end
    end

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`endif

    // One iteration step: hi holds partial product / partial remainder, lo the multiplier / dividend.
    logic [XLEN:0]   add_sum, shifted;
    logic [XLEN-1:0] rem_sub, hi_n, lo_n;

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        rem_sub = shifted[XLEN-1:0] - opnd_q;
        hi_n    = add_sum[XLEN:1];
        lo_n    = {add_sum[0], lo_q[XLEN-1:1]};
        if (ctx_q.op[2]) begin
            if (shifted >= {1'b0, opnd_q}) begin
                hi_n = rem_sub;
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            ctx_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (io.flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (io.in_valid_i) begin
                    ctx_q.op  <= io.op_i;
                    ctx_q.neg <= neg_acc;
                    hi_q      <= '0;
                    lo_q      <= mag_a;
                    opnd_q    <= mag_b;
                    cnt_q     <= CNT_WIDTH'(XLEN - 1);
                    if (special) begin
                        result_q <= special_res;
                        state_q  <= DONE;
                    end
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    else if (!io.op_i[2]) begin
                        result_q <= finalize(io.op_i, neg_acc, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
                        state_q  <= DONE;
                    end
`endif
                    else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (cnt_q == '0) begin
                        result_q <= finalize(ctx_q.op, ctx_q.neg, hi_n, lo_n);
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                DONE: if (io.out_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready_o  = (state_q == IDLE);
    assign io.out_valid_o = (state_q == DONE);
    assign io.busy_o      = (state_q != IDLE);
    assign io.result_o    = result_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Randomized and directed bench for riscv_muldiv_unit against a transaction-level model
// (64-bit arithmetic for results, a latency countdown for the handshake timing).
module tb_riscv_muldiv_unit;
    localparam int XLEN = 32;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    riscv_muldiv_unit_if #(.XLEN(XLEN)) io();
    riscv_muldiv_unit #(.XLEN(XLEN)) dut (.clk_i(clk), .arst_n_i(rst_n), .io(io));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: r = sa * sb;
            3'd1: begin r = sa * sb; r = r >>> 32; end
            3'd2: begin r = sa * ub; r = r >>> 32; end
            3'd3: begin r = ua * ub; r = r >> 32; end
            3'd4: r = (b == 0) ? -1 : sa / sb;
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : sa % sb;
            default: r = (b == 0) ? sa : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int lat_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        if (!op[2] && FAST) return 1;
        return XLEN + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: busy from accept to consume, done after the op's latency has elapsed.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    int          m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (io.flush_i) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (io.in_valid_i) begin
                m_busy <= 1'b1;
                m_res  <= ref_result(io.op_i, io.a_i, io.b_i);
                m_cnt  <= lat_fn(io.op_i, io.a_i, io.b_i) - 1;
                m_done <= (lat_fn(io.op_i, io.a_i, io.b_i) == 1);
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (io.out_ready_i) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(io.in_ready_o), 32'(!m_busy));
            check("busy", 32'(io.busy_o), 32'(m_busy));
            check("out_valid", 32'(io.out_valid_o), 32'(m_done));
            if (m_done) check("result", io.result_o, m_res);
        end
    end

    // Issue one op; optionally pin latency and result to a literal, hold off the consumer,
    // or flush at a given cycle after accept instead of consuming.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit chk, input logic [31:0] lit, input int flush_at);
        int n;
        int cyc;
        n = 0;
        while (!io.in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready_o) begin
            timeout("in_ready_wait");
            return;
        end
        io.in_valid_i = 1'b1;
        io.op_i       = op;
        io.a_i        = a;
        io.b_i        = b;
        @(negedge clk);
        io.in_valid_i = 1'b0;
        io.op_i       = 3'($urandom);
        io.a_i        = $urandom;
        io.b_i        = $urandom;
        cyc = 1;
        while (!io.out_valid_o && cyc < 100) begin
            if (cyc == flush_at) begin
                io.flush_i    = 1'b1;
                io.in_valid_i = 1'b1;
                @(negedge clk);
                io.flush_i    = 1'b0;
                io.in_valid_i = 1'b0;
                check("flush_out_valid", 32'(io.out_valid_o), 32'd0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        if (!io.out_valid_o) begin
            timeout("out_valid_wait");
            return;
        end
        if (chk) begin
            check("latency", 32'(cyc), 32'(lat_fn(op, a, b)));
            check("literal", io.result_o, lit);
            check("model_pin", ref_result(op, a, b), lit);
        end
        repeat (hold) begin
            io.in_valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        io.in_valid_i  = 1'b0;
        io.out_ready_i = 1'b1;
        @(negedge clk);
        io.out_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        io.flush_i     = 1'b0;
        io.in_valid_i  = 1'b0;
        io.op_i        = 3'd0;
        io.a_i         = '0;
        io.b_i         = '0;
        io.out_ready_i = 1'b0;
        #12;
        check("rst_out_valid", 32'(io.out_valid_o), 32'd0);
        check("rst_busy", 32'(io.busy_o), 32'd0);
        check("rst_result", io.result_o, 32'd0);
        check("rst_in_ready", 32'(io.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, 1, 32'hFFFFFFEB, -1);
        run_op(3'd1, 32'h80000000, 32'h80000000, 0, 1, 32'h40000000, -1);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, -1);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFE, -1);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0, 1, 32'hFFFFFFFD, -1);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0, 1, 32'hFFFFFFFF, -1);
        run_op(3'd5, 32'd7, 32'd2, 0, 1, 32'd3, -1);
        run_op(3'd7, 32'd7, 32'd2, 0, 1, 32'd1, -1);
        run_op(3'd5, 32'd5, 32'd0, 0, 1, 32'hFFFFFFFF, -1);
        run_op(3'd6, 32'd5, 32'd0, 0, 1, 32'd5, -1);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h80000000, -1);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h0, -1);
        // Backpressure with stray in_valid while the result is held
        run_op(3'd0, 32'd123, 32'd456, 10, 1, 32'd56088, -1);
        // Abort mid-CALC, then a clean divide
        run_op(3'd4, 32'd1000, 32'd3, 0, 0, 32'd0, 11);
        run_op(3'd5, 32'd100, 32'd7, 0, 1, 32'd14, -1);

        // Flush in DONE together with out_ready: result is dropped, unit is idle afterwards
        io.in_valid_i = 1'b1;
        io.op_i       = 3'd5;
        io.a_i        = 32'd5;
        io.b_i        = 32'd0;
        @(negedge clk);
        io.in_valid_i = 1'b0;
        check("special_1cycle", 32'(io.out_valid_o), 32'd1);
        io.flush_i     = 1'b1;
        io.out_ready_i = 1'b1;
        @(negedge clk);
        io.flush_i     = 1'b0;
        io.out_ready_i = 1'b0;
        check("done_flush_idle", 32'(io.in_ready_o), 32'd1);

        // Asynchronous reset mid-CALC
        io.in_valid_i = 1'b1;
        io.op_i       = 3'd4;
        io.a_i        = 32'd999;
        io.b_i        = 32'd5;
        @(negedge clk);
        io.in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(io.out_valid_o), 32'd0);
        check("arst_busy", 32'(io.busy_o), 32'd0);
        check("arst_result", io.result_o, 32'd0);
        check("arst_in_ready", 32'(io.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd5, 32'd100, 32'd7, 0, 1, 32'd14, -1);

        for (int i = 0; i < 80; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3), 0, 32'd0,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : -1);
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        timeout("watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
